// File: rtl/idma_error_reporter.sv
// Error reporter downstream of the iDMA error handler: forwards the 1D response stream,
// captures error responses, raises an interrupt and returns a CONTINUE/ABORT decision.
module idma_error_reporter #(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned CntWidth     = 8,
  parameter bit          ReportErrors = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // response stream from the error handler
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic                 rsp_error_i,
  input  logic                 rsp_last_i,
  input  logic [1:0]           rsp_cause_i,
  input  logic [1:0]           rsp_err_type_i,
  input  logic [AddrWidth-1:0] rsp_burst_addr_i,
  // response stream to the frontend
  output logic                 fe_rsp_valid_o,
  input  logic                 fe_rsp_ready_i,
  output logic                 fe_rsp_last_o,
  output logic                 fe_rsp_error_o,
  // decision back to the error handler
  output logic                 eh_o,
  output logic                 eh_valid_o,
  input  logic                 eh_ready_i,
  // policy and software control
  input  logic [1:0]           policy_i,
  input  logic                 sw_action_valid_i,
  input  logic                 sw_action_i,
  // status
  output logic                 err_pending_o,
  output logic [1:0]           err_cause_o,
  output logic [1:0]           err_type_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 irq_o,
  output logic [CntWidth-1:0]  err_count_o,
  input  logic                 err_count_clr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPORT = 2'd1,
    DECIDE = 2'd2,
    ISSUE  = 2'd3
  } state_e;

  localparam logic [1:0] POL_AUTO_CONT  = 2'b01;
  localparam logic [1:0] POL_AUTO_ABORT = 2'b10;

  // CntWidth must be at least 2
  localparam logic [CntWidth-1:0] CNT_MAX = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] CNT_ONE = {{(CntWidth-1){1'b0}}, 1'b1};

  function automatic logic is_auto(input logic [1:0] pol);
    return (pol == POL_AUTO_CONT) || (pol == POL_AUTO_ABORT);
  endfunction

  state_e                 state_q,   state_d;
  logic [1:0]             cause_q,   cause_d;
  logic [1:0]             type_q,    type_d;
  logic [AddrWidth-1:0]   addr_q,    addr_d;
  logic                   last_q,    last_d;
  logic [1:0]             policy_q,  policy_d;
  logic                   action_q,  action_d;
  logic                   pending_q, pending_d;
  logic                   irq_q,     irq_d;
  logic [CntWidth-1:0]    count_q,   count_d;
  logic                   capture_s;

  assign capture_s = (state_q == IDLE) && rsp_valid_i && rsp_error_i;

  // Next-state, capture and decision logic
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    type_d    = type_q;
    addr_d    = addr_q;
    last_d    = last_q;
    policy_d  = policy_q;
    action_d  = action_q;
    pending_d = pending_q;

    case (state_q)
      IDLE: begin
        if (capture_s) begin
          cause_d   = rsp_cause_i;
          type_d    = rsp_err_type_i;
          addr_d    = rsp_burst_addr_i;
          last_d    = rsp_last_i;
          policy_d  = policy_i;
          // manual policies get their action later from software
          action_d  = (policy_i == POL_AUTO_ABORT);
          pending_d = 1'b1;
          if (ReportErrors) begin
            state_d = REPORT;
          end else if (is_auto(policy_i)) begin
            state_d = ISSUE;
          end else begin
            state_d = DECIDE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REPORT: begin
        if (fe_rsp_ready_i) begin
          state_d = is_auto(policy_q) ? ISSUE : DECIDE;
        end else begin
          state_d = REPORT;
        end
      end
      DECIDE: begin
        if (sw_action_valid_i) begin
          action_d = sw_action_i;
          state_d  = ISSUE;
        end else begin
          state_d = DECIDE;
        end
      end
      ISSUE: begin
        if (eh_ready_i) begin
          pending_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    irq_d = (state_d == DECIDE) && (state_q != DECIDE);
  end

  // Saturating error counter; a clear coinciding with a capture counts that capture
  always_comb begin
    count_d = count_q;
    if (err_count_clr_i) begin
      count_d = capture_s ? CNT_ONE : {CntWidth{1'b0}};
    end else if (capture_s && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // State and status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cause_q   <= 2'b00;
      type_q    <= 2'b00;
      addr_q    <= {AddrWidth{1'b0}};
      last_q    <= 1'b0;
      policy_q  <= 2'b00;
      action_q  <= 1'b0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
      count_q   <= {CntWidth{1'b0}};
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      policy_q  <= policy_d;
      action_q  <= action_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      count_q   <= count_d;
    end
  end

  // Stream handshakes: zero-latency pass-through in IDLE, error beat replay in REPORT
  always_comb begin
    rsp_ready_o    = 1'b0;
    fe_rsp_valid_o = 1'b0;
    fe_rsp_last_o  = 1'b0;
    fe_rsp_error_o = 1'b0;
    case (state_q)
      IDLE: begin
        fe_rsp_last_o = rsp_last_i;
        if (rsp_valid_i && rsp_error_i) begin
          rsp_ready_o    = 1'b1;
          fe_rsp_valid_o = 1'b0;
        end else begin
          rsp_ready_o    = fe_rsp_ready_i;
          fe_rsp_valid_o = rsp_valid_i;
        end
      end
      REPORT: begin
        fe_rsp_valid_o = 1'b1;
        fe_rsp_error_o = 1'b1;
        fe_rsp_last_o  = last_q;
      end
      DECIDE: begin
        rsp_ready_o = 1'b0;
      end
      ISSUE: begin
        rsp_ready_o = 1'b0;
      end
      default: begin
        rsp_ready_o = 1'b0;
      end
    endcase
  end

  assign eh_valid_o    = (state_q == ISSUE);
  assign eh_o          = action_q;
  assign irq_o         = irq_q;
  assign err_pending_o = pending_q;
  assign err_cause_o   = cause_q;
  assign err_type_o    = type_q;
  assign err_addr_o    = addr_q;
  assign err_count_o   = count_q;

endmodule

// File: tb/tb_idma_error_reporter.sv
// Randomized transaction-level bench for idma_error_reporter with a narrow (2-bit) counter.
module tb_idma_error_reporter;

  localparam int AW   = 32;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          rsp_valid_i, rsp_ready_o, rsp_error_i, rsp_last_i;
  logic [1:0]    rsp_cause_i, rsp_err_type_i;
  logic [AW-1:0] rsp_burst_addr_i;
  logic          fe_rsp_valid_o, fe_rsp_ready_i, fe_rsp_last_o, fe_rsp_error_o;
  logic          eh_o, eh_valid_o, eh_ready_i;
  logic [1:0]    policy_i;
  logic          sw_action_valid_i, sw_action_i;
  logic          err_pending_o;
  logic [1:0]    err_cause_o, err_type_o;
  logic [AW-1:0] err_addr_o;
  logic          irq_o;
  logic [CW-1:0] err_count_o;
  logic          err_count_clr_i;

  idma_error_reporter #(.AddrWidth(AW), .CntWidth(CW), .ReportErrors(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_error_i(rsp_error_i),
    .rsp_last_i(rsp_last_i), .rsp_cause_i(rsp_cause_i), .rsp_err_type_i(rsp_err_type_i),
    .rsp_burst_addr_i(rsp_burst_addr_i),
    .fe_rsp_valid_o(fe_rsp_valid_o), .fe_rsp_ready_i(fe_rsp_ready_i),
    .fe_rsp_last_o(fe_rsp_last_o), .fe_rsp_error_o(fe_rsp_error_o),
    .eh_o(eh_o), .eh_valid_o(eh_valid_o), .eh_ready_i(eh_ready_i),
    .policy_i(policy_i), .sw_action_valid_i(sw_action_valid_i), .sw_action_i(sw_action_i),
    .err_pending_o(err_pending_o), .err_cause_o(err_cause_o), .err_type_o(err_type_o),
    .err_addr_o(err_addr_o), .irq_o(irq_o), .err_count_o(err_count_o),
    .err_count_clr_i(err_count_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  // reference view of the status block
  int          exp_cnt   = 0;
  logic [1:0]  exp_cause = 2'd0;
  logic [1:0]  exp_type  = 2'd0;
  logic [31:0] exp_addr  = 32'd0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet_inputs();
    rsp_valid_i = 1'b0; rsp_error_i = 1'b0; rsp_last_i = 1'b0;
    rsp_cause_i = 2'd0; rsp_err_type_i = 2'd0; rsp_burst_addr_i = '0;
    fe_rsp_ready_i = 1'b0; eh_ready_i = 1'b0; policy_i = 2'd0;
    sw_action_valid_i = 1'b0; sw_action_i = 1'b0; err_count_clr_i = 1'b0;
  endtask

  task automatic check_status(input string ctx);
    check_val({ctx, "_cnt"},   64'(err_count_o), 64'(exp_cnt));
    check_val({ctx, "_cause"}, 64'(err_cause_o), 64'(exp_cause));
    check_val({ctx, "_type"},  64'(err_type_o),  64'(exp_type));
    check_val({ctx, "_addr"},  64'(err_addr_o),  64'(exp_addr));
  endtask

  task automatic ok_beat(input logic last, input logic rdy);
    rsp_valid_i = 1'b1; rsp_error_i = 1'b0; rsp_last_i = last; fe_rsp_ready_i = rdy;
    rsp_cause_i = 2'($urandom); rsp_burst_addr_i = $urandom;
    sw_action_valid_i = 1'($urandom); sw_action_i = 1'($urandom); eh_ready_i = 1'($urandom);
    #1;
    check_val("ok_fe_valid", 64'(fe_rsp_valid_o), 64'd1);
    check_val("ok_fe_last",  64'(fe_rsp_last_o),  64'(last));
    check_val("ok_fe_error", 64'(fe_rsp_error_o), 64'd0);
    check_val("ok_rsp_ready", 64'(rsp_ready_o),   64'(rdy));
    tick();
    quiet_inputs();
    #1;
    check_val("ok_eh_valid", 64'(eh_valid_o), 64'd0);
    check_val("ok_pending",  64'(err_pending_o), 64'd0);
    check_status("ok");
  endtask

  task automatic clr_only();
    quiet_inputs();
    err_count_clr_i = 1'b1;
    tick();
    err_count_clr_i = 1'b0;
    exp_cnt = 0;
    check_val("clr_cnt", 64'(err_count_o), 64'd0);
  endtask

  task automatic error_txn(input logic [1:0] cause, input logic [1:0] typ, input logic [31:0] addr,
                           input logic last, input logic [1:0] pol, input int fe_stall,
                           input int sw_delay, input int eh_stall, input logic act, input logic clr);
    logic manual;
    logic exp_eh;
    manual = !(pol == 2'b01 || pol == 2'b10);
    exp_eh = manual ? act : (pol == 2'b10);

    rsp_valid_i = 1'b1; rsp_error_i = 1'b1; rsp_last_i = last; rsp_cause_i = cause;
    rsp_err_type_i = typ; rsp_burst_addr_i = addr; policy_i = pol; err_count_clr_i = clr;
    fe_rsp_ready_i = 1'($urandom);
    #1;
    check_val("cap_rsp_ready", 64'(rsp_ready_o), 64'd1);
    check_val("cap_fe_valid",  64'(fe_rsp_valid_o), 64'd0);
    tick();
    exp_cnt   = clr ? 1 : ((exp_cnt < CMAX) ? exp_cnt + 1 : CMAX);
    exp_cause = cause; exp_type = typ; exp_addr = addr;

    // a second response waits upstream; policy changes must not matter now
    err_count_clr_i = 1'b0; rsp_error_i = 1'($urandom); policy_i = 2'($urandom);
    for (int k = 0; k <= fe_stall; k++) begin
      fe_rsp_ready_i = (k == fe_stall);
      sw_action_valid_i = 1'($urandom); sw_action_i = 1'($urandom); eh_ready_i = 1'($urandom);
      #1;
      check_val("rep_fe_valid", 64'(fe_rsp_valid_o), 64'd1);
      check_val("rep_fe_error", 64'(fe_rsp_error_o), 64'd1);
      check_val("rep_fe_last",  64'(fe_rsp_last_o),  64'(last));
      check_val("rep_rsp_ready", 64'(rsp_ready_o),   64'd0);
      check_val("rep_eh_valid", 64'(eh_valid_o),     64'd0);
      check_val("rep_irq",      64'(irq_o),          64'd0);
      check_val("rep_pending",  64'(err_pending_o),  64'd1);
      check_status("rep");
      tick();
    end
    fe_rsp_ready_i = 1'($urandom);

    if (manual) begin
      for (int d = 0; d <= sw_delay; d++) begin
        sw_action_valid_i = (d == sw_delay);
        sw_action_i = (d == sw_delay) ? act : 1'($urandom);
        eh_ready_i = 1'($urandom);
        #1;
        check_val("dec_irq",       64'(irq_o),         64'(d == 0));
        check_val("dec_eh_valid",  64'(eh_valid_o),    64'd0);
        check_val("dec_fe_valid",  64'(fe_rsp_valid_o), 64'd0);
        check_val("dec_rsp_ready", 64'(rsp_ready_o),   64'd0);
        check_val("dec_pending",   64'(err_pending_o), 64'd1);
        tick();
      end
    end

    for (int e = 0; e <= eh_stall; e++) begin
      eh_ready_i = (e == eh_stall);
      sw_action_valid_i = 1'($urandom); sw_action_i = 1'($urandom);
      #1;
      check_val("iss_eh_valid",  64'(eh_valid_o),    64'd1);
      check_val("iss_eh",        64'(eh_o),          64'(exp_eh));
      check_val("iss_irq",       64'(irq_o),         64'd0);
      check_val("iss_rsp_ready", 64'(rsp_ready_o),   64'd0);
      check_val("iss_fe_valid",  64'(fe_rsp_valid_o), 64'd0);
      check_val("iss_pending",   64'(err_pending_o), 64'd1);
      tick();
    end

    quiet_inputs();
    fe_rsp_ready_i = 1'b1;
    #1;
    check_val("done_pending",   64'(err_pending_o), 64'd0);
    check_val("done_eh_valid",  64'(eh_valid_o),    64'd0);
    check_val("done_rsp_ready", 64'(rsp_ready_o),   64'd1);
    check_status("done");
    fe_rsp_ready_i = 1'b0;
  endtask

  task automatic reset_in_decide();
    rsp_valid_i = 1'b1; rsp_error_i = 1'b1; rsp_cause_i = 2'd3; rsp_err_type_i = 2'd2;
    rsp_burst_addr_i = 32'hDEAD_0040; policy_i = 2'b00;
    tick();
    rsp_valid_i = 1'b0; fe_rsp_ready_i = 1'b1;
    tick();
    fe_rsp_ready_i = 1'b0;
    #1;
    check_val("rst_dec_irq", 64'(irq_o), 64'd1);
    rst_i = 1'b1; sw_action_valid_i = 1'b1; sw_action_i = 1'b1;
    tick();
    rst_i = 1'b0; sw_action_valid_i = 1'b0; sw_action_i = 1'b0;
    exp_cnt = 0; exp_cause = 2'd0; exp_type = 2'd0; exp_addr = 32'd0;
    #1;
    check_val("rst_pending",  64'(err_pending_o), 64'd0);
    check_val("rst_eh_valid", 64'(eh_valid_o),    64'd0);
    check_val("rst_irq",      64'(irq_o),         64'd0);
    check_status("rst");
    sw_action_valid_i = 1'b1; sw_action_i = 1'b1;
    tick();
    sw_action_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("post_rst_eh_valid", 64'(eh_valid_o), 64'd0);
      check_val("post_rst_eh",       64'(eh_o),       64'd0);
      check_val("post_rst_pending",  64'(err_pending_o), 64'd0);
      tick();
    end
  endtask

  initial begin
    quiet_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    check_val("reset_eh_valid", 64'(eh_valid_o),     64'd0);
    check_val("reset_irq",      64'(irq_o),          64'd0);
    check_val("reset_pending",  64'(err_pending_o),  64'd0);
    check_val("reset_eh",       64'(eh_o),           64'd0);
    check_val("reset_fe_valid", 64'(fe_rsp_valid_o), 64'd0);
    check_status("reset");
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) ok_beat(1'(i == 2), 1'b1);
    error_txn(2'd2, 2'd1, 32'h0000_1000, 1'b1, 2'b01, 0, 0, 0, 1'b0, 1'b0);
    error_txn(2'd1, 2'd0, 32'h0000_2004, 1'b0, 2'b00, 0, 3, 5, 1'b1, 1'b0);
    error_txn(2'd3, 2'd2, 32'h0000_3008, 1'b1, 2'b10, 4, 0, 1, 1'b0, 1'b0);
    ok_beat(1'b1, 1'b1);
    clr_only();
    for (int i = 0; i < 5; i++)
      error_txn(2'($urandom), 2'($urandom), $urandom, 1'($urandom), 2'b01, 0, 0, 0, 1'b0, 1'b0);
    error_txn(2'd0, 2'd3, 32'h0000_4000, 1'b0, 2'b11, 1, 1, 0, 1'b0, 1'b1);
    reset_in_decide();

    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 5);
      if (r < 2) begin
        ok_beat(1'($urandom), 1'($urandom));
      end else if (r < 5) begin
        error_txn(2'($urandom), 2'($urandom), $urandom, 1'($urandom), 2'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), ($urandom_range(0, 3) == 0));
      end else begin
        clr_only();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/idma_error_reporter.md
Name: idma_error_reporter

Overview:
Sits directly downstream of the iDMA error handler. It consumes the 1D response stream and forwards it to the frontend. On an error response it captures the error into status registers and raises an interrupt. It then returns the CONTINUE/ABORT decision to the error handler's eh request port, either automatically (per a policy) or on software command.

Parameters:
AddrWidth, 32, width of captured burst address
CntWidth, 8, width of saturating error counter
ReportErrors, 1, 1: forward error responses to the frontend; 0: consume them silently

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
rsp_valid_i  in  1  response valid from error handler
rsp_ready_o  out  1  response ready to error handler
rsp_error_i  in  1  response carries an error
rsp_last_i  in  1  response last flag
rsp_cause_i  in  2  AXI resp code of error
rsp_err_type_i  in  2  error type (BUS_READ/BUS_WRITE/...)
rsp_burst_addr_i  in  AddrWidth  faulting burst address
fe_rsp_valid_o  out  1  response valid to frontend
fe_rsp_ready_i  in  1  frontend ready
fe_rsp_last_o  out  1  forwarded last flag
fe_rsp_error_o  out  1  forwarded error flag
eh_o  out  1  decision, 0=CONTINUE, 1=ABORT
eh_valid_o  out  1  decision valid to error handler
eh_ready_i  in  1  error handler accepts decision
policy_i  in  2  00 manual, 01 auto-continue, 10 auto-abort, 11 treated as manual
sw_action_valid_i  in  1  software decision strobe
sw_action_i  in  1  software decision, 0=CONTINUE, 1=ABORT
err_pending_o  out  1  captured error awaiting resolution
err_cause_o  out  2  captured cause
err_type_o  out  2  captured type
err_addr_o  out  AddrWidth  captured address
irq_o  out  1  one-cycle interrupt pulse
err_count_o  out  CntWidth  saturating count of captured errors
err_count_clr_i  in  1  clear error counter

Behaviour:
- Single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - state IDLE.
  - All valid outputs, irq_o, err_pending_o and eh_o are 0.
  - Capture registers and counter are 0.
  - rsp_ready_o is 0 except as defined in IDLE.
- Reset mid-operation abandons any pending error. No decision is emitted.
- FSM states: IDLE, REPORT, DECIDE, ISSUE.
- IDLE, non-error response:
  - Combinational pass-through: fe_rsp_valid_o = rsp_valid_i & !rsp_error_i.
  - rsp_ready_o = fe_rsp_ready_i.
  - fe_rsp_last_o = rsp_last_i; fe_rsp_error_o = 0.
  - Zero latency.
- IDLE, error response (rsp_valid_i & rsp_error_i):
  - rsp_ready_o = 1; the response is not forwarded combinationally.
  - Capture cause, type, address, last and policy_i. Policy is latched here and later policy_i changes are ignored for this error.
  - Set err_pending_o and increment the counter.
  - Next state: REPORT if ReportErrors=1, otherwise the post-REPORT target.
- REPORT:
  - fe_rsp_valid_o = 1, fe_rsp_error_o = 1, fe_rsp_last_o = captured last.
  - rsp_ready_o = 0.
  - On fe_rsp_ready_i: go to ISSUE if the latched policy is auto, else go to DECIDE.
- DECIDE:
  - irq_o pulses 1 in the first cycle after entering DECIDE.
  - Wait for sw_action_valid_i, then latch sw_action_i into eh_o and go to ISSUE.
  - sw_action_valid_i is ignored in every other state.
- ISSUE:
  - eh_valid_o = 1. eh_o is the latched action (auto-continue gives 0, auto-abort gives 1). eh_o is held stable while valid.
  - On eh_ready_i: clear err_pending_o and go to IDLE.
  - A new error can be captured in the cycle after returning to IDLE.
- Upstream is back-pressured (rsp_ready_o = 0) in REPORT, DECIDE and ISSUE.
- Latency: error accepted in cycle N → fe_rsp_valid_o in N+1. Frontend handshake in M → eh_valid_o in M+1 (auto policy).
- Counter:
  - +1 per captured error, saturating at 2^CntWidth-1. No wrap.
  - err_count_clr_i resets it to 0.
  - Clear and capture in the same cycle → 1.
- Capture registers hold their values until the next capture. They are not cleared on resolve.

Test Plan:
- Three OK responses with fe_rsp_ready_i=1 → three zero-latency frontend beats, error=0; err_count_o stays 0; eh_valid_o never asserted.
- Error (cause=2, type=BUS_WRITE, addr=0x1000) with policy=01 → REPORT beat error=1 in next cycle; eh_valid_o=1, eh_o=0 one cycle after frontend handshake; err_addr_o=0x1000; err_count_o=1.
- Error with policy=00 → irq_o single-cycle pulse; state holds until sw_action_valid_i=1, sw_action_i=1; then eh_o=1, eh_valid_o held 5 cycles with eh_ready_i=0 and eh_o stable; err_pending_o clears after handshake.
- Back-pressure: fe_rsp_ready_i=0 for 4 cycles in REPORT, with a second valid response waiting upstream → rsp_ready_o=0 throughout; second response accepted only after ISSUE completes.
- Counter: CntWidth=2 with 5 auto-continue errors → err_count_o saturates at 3; clear and capture in the same cycle → 1.
- Reset asserted while in DECIDE → next cycle state IDLE; err_pending_o, eh_valid_o, irq_o = 0; a subsequent sw_action_valid_i has no effect.
